// File: rtl/fpa_norm_if.sv
// Bus between the F-PA arithmetic unit and its normalisation sequencer.
// The master side is F-PA (T status lines, start/ovf, unnormalised exponent).
// The slave side is fpa_norm (shift/clear requests, result exponent and flags).
// Exponents are two's complement, numbered MSB-first [0:EXP_W-1].
interface fpa_norm_if #(
    parameter int EXP_W = 8
);
    // Control from F-PA
    logic             start;
    logic             ovf;
    logic [0:EXP_W-1] exp_in;

    // T-register status lines, combinational from T
    logic             t0;
    logic             t1;
    logic             t_0_1;
    logic             t_2_7;
    logic             t_8_15;
    logic             t_16_23;
    logic             t_24_31;
    logic             t_32_39;

    // Requests and results from the sequencer
    logic             busy;
    logic             done;
    logic             shl;
    logic             shr;
    logic             zt;
    logic [0:EXP_W-1] exp_out;
    logic             zero;
    logic             uf;
    logic             of;

    modport master (
        output start, ovf, exp_in,
        output t0, t1, t_0_1, t_2_7, t_8_15, t_16_23, t_24_31, t_32_39,
        input  busy, done, shl, shr, zt, exp_out, zero, uf, of
    );

    modport slave (
        input  start, ovf, exp_in,
        input  t0, t1, t_0_1, t_2_7, t_8_15, t_16_23, t_24_31, t_32_39,
        output busy, done, shl, shr, zt, exp_out, zero, uf, of
    );
endinterface

// File: rtl/fpa_norm.sv
// Normalisation sequencer for the F-PA unit.
// After an add/sub/mul it requests one-bit left shifts of T/M until t0 != t1,
// decrementing the exponent once per shift, and flags zero / underflow.
// Optional macro FPA_NORM_RIGHT_EN: on start with ovf=1, issue a single
// arithmetic right shift and increment the exponent (or flag overflow at the
// most positive exponent). Without it, ovf is ignored and shr/of are tied 0.
module fpa_norm #(
    parameter int EXP_W     = 8,
    parameter int MAX_SHIFT = 39
) (
    input  logic          clk_sys,
    input  logic          clr,
    fpa_norm_if.slave     bus
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    localparam logic [0:EXP_W-1] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};
`ifdef FPA_NORM_RIGHT_EN
    localparam logic [0:EXP_W-1] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};
`endif

`ifdef FPA_NORM_RIGHT_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SHIFT  = 3'd2,
        RSHIFT = 3'd3,
        DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SHIFT  = 3'd2,
        DONE   = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [0:EXP_W-1] exp_q,   exp_d;
    logic             zero_q,  zero_d;
    logic             uf_q,    uf_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             shl_c;
    logic             zt_c;
    logic             done_c;

`ifdef FPA_NORM_RIGHT_EN
    logic             of_q, of_d;
    logic             shr_c;
`else
    // ovf has no meaning when the right-shift path is not built.
    logic             unused_ovf;
    assign unused_ovf = bus.ovf;
`endif

    // Any bit of T set; all six OR-groups clear means a zero mantissa.
    logic t_nonzero;
    assign t_nonzero = bus.t_0_1 | bus.t_2_7 | bus.t_8_15 |
                       bus.t_16_23 | bus.t_24_31 | bus.t_32_39;

    // Top two bits disagree: mantissa is already normalised.
    logic t_norm;
    assign t_norm = bus.t0 ^ bus.t1;

    // Next-state, next-data and per-state request decoding.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        uf_d    = uf_q;
        cnt_d   = cnt_q;
        shl_c   = 1'b0;
        zt_c    = 1'b0;
        done_c  = 1'b0;
`ifdef FPA_NORM_RIGHT_EN
        of_d    = of_q;
        shr_c   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    exp_d  = bus.exp_in;
                    zero_d = 1'b0;
                    uf_d   = 1'b0;
                    cnt_d  = '0;
`ifdef FPA_NORM_RIGHT_EN
                    of_d   = 1'b0;
                    if (bus.ovf) begin
                        if (bus.exp_in == EXP_MAX) begin
                            // Exponent cannot absorb the carry: flag and skip the shift.
                            of_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = RSHIFT;
                        end
                    end else begin
                        state_d = CHECK;
                    end
`else
                    state_d = CHECK;
`endif
                end
            end

            CHECK: begin
                if (!t_nonzero) begin
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = DONE;
                end else if (t_norm) begin
                    state_d = DONE;
                end else if (exp_q == EXP_MIN) begin
                    // Another shift would take the exponent below range: flush T.
                    uf_d    = 1'b1;
                    zt_c    = 1'b1;
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(MAX_SHIFT)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                shl_c   = 1'b1;
                exp_d   = exp_q - EXP_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = CHECK;
            end

`ifdef FPA_NORM_RIGHT_EN
            RSHIFT: begin
                shr_c   = 1'b1;
                exp_d   = exp_q + EXP_W'(1);
                state_d = DONE;
            end
`endif

            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (clr) begin
            state_q <= IDLE;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef FPA_NORM_RIGHT_EN
            of_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            uf_q    <= uf_d;
            cnt_q   <= cnt_d;
`ifdef FPA_NORM_RIGHT_EN
            of_q    <= of_d;
`endif
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_c;
    assign bus.shl     = shl_c;
    assign bus.zt      = zt_c;
    assign bus.exp_out = exp_q;
    assign bus.zero    = zero_q;
    assign bus.uf      = uf_q;
`ifdef FPA_NORM_RIGHT_EN
    assign bus.shr     = shr_c;
    assign bus.of      = of_q;
`else
    assign bus.shr     = 1'b0;
    assign bus.of      = 1'b0;
`endif

endmodule

// File: tb/tb_fpa_norm.sv
// Bench for fpa_norm: a small F-PA T-register model reacts to shl/shr/zt,
// directed vectors push hand-computed results into a scoreboard queue, and a
// monitor pops and compares on every done pulse.
module tb_fpa_norm;

    localparam int EXP_W = 8;

    logic clk_sys = 1'b0;
    logic clr;
    always #5 clk_sys = ~clk_sys;

    fpa_norm_if #(.EXP_W(EXP_W)) ifc ();

    fpa_norm #(.EXP_W(EXP_W), .MAX_SHIFT(39)) dut (
        .clk_sys (clk_sys),
        .clr     (clr),
        .bus     (ifc.slave)
    );

    // F-PA T-register model, T[0] is the MSB (bit 39 here).
    logic [39:0] t_reg;
    logic [39:0] t_ld_val;
    logic        t_ld;

    always @(posedge clk_sys) begin
        if (t_ld)          t_reg <= t_ld_val;
        else if (ifc.shl)  t_reg <= {t_reg[38:0], 1'b0};
        else if (ifc.shr)  t_reg <= {t_reg[39], t_reg[39:1]};
        else if (ifc.zt)   t_reg <= '0;
    end

    assign ifc.t0      = t_reg[39];
    assign ifc.t1      = t_reg[38];
    assign ifc.t_0_1   = |t_reg[39:38];
    assign ifc.t_2_7   = |t_reg[37:32];
    assign ifc.t_8_15  = |t_reg[31:24];
    assign ifc.t_16_23 = |t_reg[23:16];
    assign ifc.t_24_31 = |t_reg[15:8];
    assign ifc.t_32_39 = |t_reg[7:0];

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] exp;
        logic       zero;
        logic       uf;
        logic       of;
        int         nshl;
        int         nshr;
        int         nzt;
        int         lat;
        int         start_cyc;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: count requests during a sequence, compare results on done.
    initial begin
        int   shl_cnt = 0;
        int   shr_cnt = 0;
        int   zt_cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (!ifc.busy) begin
                shl_cnt = 0;
                shr_cnt = 0;
                zt_cnt  = 0;
            end else begin
                if (ifc.shl) shl_cnt++;
                if (ifc.shr) shr_cnt++;
                if (ifc.zt)  zt_cnt++;
            end
            if (ifc.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, ".exp_out"}, 32'(ifc.exp_out), 32'(e.exp));
                    check({e.name, ".zero"},    32'(ifc.zero),    32'(e.zero));
                    check({e.name, ".uf"},      32'(ifc.uf),      32'(e.uf));
                    check({e.name, ".of"},      32'(ifc.of),      32'(e.of));
                    check({e.name, ".n_shl"},   32'(shl_cnt),     32'(e.nshl));
                    check({e.name, ".n_shr"},   32'(shr_cnt),     32'(e.nshr));
                    check({e.name, ".n_zt"},    32'(zt_cnt),      32'(e.nzt));
                    check({e.name, ".latency"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                end
            end
        end
    end

    // Issue one normalisation starting at a negedge and wait for it to end.
    task automatic run(input string nm, input logic [39:0] t, input logic [7:0] ein,
                       input logic ov, input logic [7:0] x_exp, input logic x_zero,
                       input logic x_uf, input logic x_of, input int x_shl,
                       input int x_shr, input int x_zt, input int x_lat);
        exp_t e;
        int   n;
        e.name = nm;   e.exp = x_exp; e.zero = x_zero; e.uf = x_uf; e.of = x_of;
        e.nshl = x_shl; e.nshr = x_shr; e.nzt = x_zt; e.lat = x_lat;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        t_ld_val   = t;
        t_ld       = 1'b1;
        ifc.exp_in = ein;
        ifc.ovf    = ov;
        ifc.start  = 1'b1;
        @(posedge clk_sys);
        #1;
        t_ld      = 1'b0;
        ifc.start = 1'b0;
        ifc.ovf   = 1'b0;
        n = 0;
        while (ifc.busy && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (ifc.busy) check({nm, ".timeout"}, 32'd1, 32'd0);
        @(negedge clk_sys);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".busy"},    32'(ifc.busy),    32'd0);
        check({nm, ".done"},    32'(ifc.done),    32'd0);
        check({nm, ".shl"},     32'(ifc.shl),     32'd0);
        check({nm, ".shr"},     32'(ifc.shr),     32'd0);
        check({nm, ".zt"},      32'(ifc.zt),      32'd0);
        check({nm, ".exp_out"}, 32'(ifc.exp_out), 32'd0);
        check({nm, ".zero"},    32'(ifc.zero),    32'd0);
        check({nm, ".uf"},      32'(ifc.uf),      32'd0);
        check({nm, ".of"},      32'(ifc.of),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        int stray;
        clr        = 1'b1;
        ifc.start  = 1'b0;
        ifc.ovf    = 1'b0;
        ifc.exp_in = '0;
        t_ld       = 1'b1;
        t_ld_val   = '0;
        repeat (3) @(negedge clk_sys);
        check_reset_outputs("reset");
        clr  = 1'b0;
        t_ld = 1'b0;
        @(negedge clk_sys);

        //   name          T               exp_in ovf  exp    zero uf  of  shl shr zt lat
        run("already_norm", 40'h4000000000, 8'h05, 0, 8'h05, 0, 0, 0,  0, 0, 0,  3);
        run("lsb_only",     40'h0000000001, 8'h00, 0, 8'hDA, 0, 0, 0, 38, 0, 0, 79);
        run("zero_t",       40'h0000000000, 8'h12, 0, 8'h00, 1, 0, 0,  0, 0, 0,  3);
        run("underflow",    40'h0100000000, 8'h81, 0, 8'h00, 1, 1, 0,  1, 0, 1,  5);
        run("minus_one",    40'hFFFFFFFFFF, 8'h00, 0, 8'hD9, 0, 0, 0, 39, 0, 0, 81);
        run("neg_one_shift",40'hC000000000, 8'h10, 0, 8'h0F, 0, 0, 0,  1, 0, 0,  5);
        run("norm_at_min",  40'h8000000000, 8'h80, 0, 8'h80, 0, 0, 0,  0, 0, 0,  3);
        run("zero_at_min",  40'h0000000000, 8'h80, 0, 8'h00, 1, 0, 0,  0, 0, 0,  3);
`ifdef FPA_NORM_RIGHT_EN
        run("ovf_at_max",   40'h4000000000, 8'h7F, 1, 8'h7F, 0, 0, 1,  0, 0, 0,  2);
        run("ovf_rshift",   40'h8000000001, 8'h05, 1, 8'h06, 0, 0, 0,  0, 1, 0,  3);
`else
        run("ovf_ignored",  40'h4000000000, 8'h7F, 1, 8'h7F, 0, 0, 0,  0, 0, 0,  3);
`endif

        // clr in the middle of a long sequence, asserted after the third shl.
        t_ld_val   = 40'h0000000001;
        t_ld       = 1'b1;
        ifc.exp_in = 8'h00;
        ifc.start  = 1'b1;
        @(posedge clk_sys);
        #1;
        t_ld      = 1'b0;
        ifc.start = 1'b0;
        s = 0;
        n = 0;
        while (s < 3 && n < 50) begin
            @(negedge clk_sys);
            n++;
            if (ifc.shl) s++;
        end
        check("clr.third_shl_seen", 32'(s), 32'd3);
        clr = 1'b1;
        @(negedge clk_sys);
        check_reset_outputs("clr_mid");
        clr   = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk_sys);
            if (ifc.shl || ifc.shr || ifc.zt || ifc.busy) stray++;
        end
        check("clr.quiet_after", 32'(stray), 32'd0);

        // Normal operation resumes after clr.
        run("after_clr",    40'h2000000000, 8'h00, 0, 8'hFF, 0, 0, 0,  1, 0, 0,  5);

        repeat (3) @(negedge clk_sys);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
